result_store_seq: RTL
=====================

Name: result_store_seq

Overview:
- Store-side sequencer that drives the testbench monitor's write port, playing the role the CPU/data-memory write path normally plays.
- Emits a start-marker write to test port 0, then NUM_WORDS result writes to ports 1..NUM_WORDS.
- Holds each write for a fixed number of cycles to emulate a D-cache stall, then deasserts wen for a gap so the monitor counts each write exactly once.
- Used for monitor self-test and for standalone bring-up without a CPU.

Parameters:
- NUM_WORDS, 3: number of result words written after the marker (1..4).
- HOLD_CYC, 2: cycles wen stays high per write (>=1).
- GAP_CYC, 1: cycles wen stays low between writes (>=1).
- MARK_VAL, 32'h00000005: data written to port 0 as the start marker.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_en  in  1  load strobe for the result buffer.
- ld_idx  in  2  buffer index to load.
- ld_data  in  32  result word to load.
- start  in  1  one-cycle pulse; begins the write sequence.
- addr  out  30  word address of the current write.
- data  out  32  write data.
- wen  out  1  write enable.
- busy  out  1  high while the sequence is running.
- done  out  1  high after the sequence completes; held until the next start or reset.

Behaviour:
- Reset (async, rst=1): state IDLE; addr=0, data=0, wen=0, busy=0, done=0; buffer words cleared to 0; counters cleared.
- All outputs are registered. Whenever wen=0, addr=0 and data=0.
- Buffer:
  - 4 x 32-bit words.
  - Written on ld_en when state is IDLE or DONE and ld_idx < NUM_WORDS.
  - Loads in any other state, or with ld_idx >= NUM_WORDS, are ignored.
- FSM states: IDLE, MARK, HOLD, GAP, DONE.
  - IDLE/DONE + start -> MARK. busy=1 and done=0 from the next edge.
  - MARK: addr=0, data=MARK_VAL, wen=1. Hold counter loaded with HOLD_CYC-1. Next state is HOLD when HOLD_CYC>1, otherwise GAP.
  - HOLD: outputs unchanged; decrement the counter; at 0 -> GAP.
  - GAP:
    - wen=0; gap counter runs GAP_CYC cycles.
    - At the end with widx < NUM_WORDS: drive addr=widx+1, data=buf[widx], wen=1, increment widx, reload the hold counter, then go to HOLD (or stay one cycle if HOLD_CYC=1 and proceed to GAP).
    - At the end with widx == NUM_WORDS: go to DONE with busy=0 and done=1.
  - DONE: outputs idle; done stays 1; start restarts the sequence (widx reset to 0).
- start while busy is ignored.
- start and ld_en in the same cycle in IDLE/DONE: the load takes effect and the sequence starts. The word loaded at index 0 is used, because buffer reads happen only after the marker write.
- Timing: start sampled at edge t. Marker wen high t+1..t+HOLD_CYC. done rises at t+1+(NUM_WORDS+1)*(HOLD_CYC+GAP_CYC).
- Reset asserted mid-sequence: immediate return to reset values. Buffer contents are lost; no partial write is completed.
- widx is 3 bits. Address arithmetic is zero-extended to 30 bits.

Decomposition:
- Shared package: state encoding constants (IDLE=0, MARK=1, HOLD=2, GAP=3, DONE=4), test-port base address 30'h0, and the default marker value.
- One natural sub-module: cyc_timer.
  - Loadable down-counter with a zero flag.
  - Instantiated twice, once for hold and once for gap.

Test Plan:
1. Load buf = {4,4,4}, start, defaults -> writes (0,5),(1,4),(2,4),(3,4); each write wen high 2 cycles then low 1 cycle; done rises 13 cycles after the start edge; the monitor reports 0 errors.
2. Load {4,7,4}, start -> port-2 write carries data 7; the monitor error_num ends at 1; done rises at the same cycle as in scenario 1.
3. HOLD_CYC=1, GAP_CYC=3 -> each wen pulse is 1 cycle, separated by 3 low cycles; done rises at start+17.
4. ld_en with idx 1 and data 9 while busy, then start again in DONE -> the second run still writes 4 at port 2; the ignored load has no effect.
5. rst pulsed during the port-2 HOLD -> wen=0, addr=0, busy=0, done=0 asynchronously; buffer reads 0. Reload and start -> a clean full sequence runs from the marker.
6. start pulsed while busy in GAP -> the sequence is unaffected and done timing is unchanged; start in DONE -> a second identical sequence runs and done drops for its duration.

Source files
------------

// File: rtl/result_store_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : result_store_seq_pkg
// Brief   : Shared state encoding and constants for the result store sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
package result_store_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MARK = 3'd1,
        ST_HOLD = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [29:0] c_TEST_PORT_BASE = 30'h0;
    localparam logic [31:0] c_DEF_MARK_VAL   = 32'h0000_0005;
    localparam int          c_TMR_W          = 8;

endpackage
`default_nettype wire

// File: rtl/result_store_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : result_store_seq_if
// Brief   : Buffer-load / start controls and monitor write port of the sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
interface result_store_seq_if;
    logic        ld_en;
    logic [1:0]  ld_idx;
    logic [31:0] ld_data;
    logic        start;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        busy;
    logic        done;

    modport master (
        output ld_en, ld_idx, ld_data, start,
        input  addr, data, wen, busy, done
    );

    modport slave (
        input  ld_en, ld_idx, ld_data, start,
        output addr, data, wen, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/result_store_seq_cyc_timer.sv
`default_nettype none
// ============================================================================
// Module  : result_store_seq_cyc_timer
// Brief   : Loadable saturating down-counter with a zero flag.
// Rev     : 1.0 - initial release
// ============================================================================
module result_store_seq_cyc_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/result_store_seq.sv
`default_nettype none
// ============================================================================
// Module  : result_store_seq
// Brief   : Drives a start marker then buffered result words onto the monitor port.
// Rev     : 1.0 - initial release
// ============================================================================
module result_store_seq
    import result_store_seq_pkg::*;
#(
    parameter int          NUM_WORDS = 3,
    parameter int          HOLD_CYC  = 2,
    parameter int          GAP_CYC   = 1,
    parameter logic [31:0] MARK_VAL  = c_DEF_MARK_VAL
) (
    input  logic               clk,
    input  logic               rst,
    result_store_seq_if.slave  bus
);

    localparam logic [c_TMR_W-1:0] c_HOLD_LD = c_TMR_W'(HOLD_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LD  = c_TMR_W'(GAP_CYC - 1);
    localparam logic [2:0]         c_NUM_W   = 3'(NUM_WORDS);

    state_t      r_state;
    logic [2:0]  r_widx;
    logic [31:0] r_buf [4];
    logic [29:0] r_addr;
    logic [31:0] r_data;
    logic        r_wen;
    logic        r_busy;
    logic        r_done;

    logic w_idle;
    logic w_more;
    logic w_hold_zero;
    logic w_gap_zero;
    logic w_hold_load;
    logic w_hold_dec;
    logic w_gap_load;
    logic w_gap_dec;

    assign w_idle      = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_more      = (r_widx < c_NUM_W);
    // A write is always followed by HOLD; with HOLD_CYC=1 the counter is
    // already zero so HOLD lasts exactly one cycle before the gap starts.
    assign w_hold_load = (r_state == ST_MARK) ||
                         ((r_state == ST_GAP) && w_gap_zero && w_more);
    assign w_hold_dec  = (r_state == ST_HOLD);
    assign w_gap_load  = (r_state == ST_HOLD) && w_hold_zero;
    assign w_gap_dec   = (r_state == ST_GAP);

    result_store_seq_cyc_timer #(.WIDTH(c_TMR_W)) u_hold_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_hold_load),
        .load_val (c_HOLD_LD),
        .dec      (w_hold_dec),
        .zero     (w_hold_zero)
    );

    result_store_seq_cyc_timer #(.WIDTH(c_TMR_W)) u_gap_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_gap_load),
        .load_val (c_GAP_LD),
        .dec      (w_gap_dec),
        .zero     (w_gap_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_widx  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_idle && bus.ld_en && ({1'b0, bus.ld_idx} < c_NUM_W)) begin
                r_buf[bus.ld_idx] <= bus.ld_data;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state <= ST_MARK;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_widx  <= '0;
                    end
                end
                ST_MARK: begin
                    r_addr  <= c_TEST_PORT_BASE;
                    r_data  <= MARK_VAL;
                    r_wen   <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_hold_zero) begin
                        r_addr  <= '0;
                        r_data  <= '0;
                        r_wen   <= 1'b0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_gap_zero) begin
                        if (w_more) begin
                            r_addr  <= c_TEST_PORT_BASE + 30'(r_widx) + 30'd1;
                            r_data  <= r_buf[r_widx[1:0]];
                            r_wen   <= 1'b1;
                            r_widx  <= r_widx + 3'd1;
                            r_state <= ST_HOLD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.addr = r_addr;
    assign bus.data = r_data;
    assign bus.wen  = r_wen;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
`default_nettype wire
